// File: rtl/dpc_axis_frame_sync.sv
// Ingress frame synchroniser: turns a raw sensor AXI4-Stream into exactly ROW x COL beats
// per frame with regenerated tuser/tlast, repairing short/long lines and truncated frames.
module dpc_axis_frame_sync #(
    parameter int unsigned ROW              = 288,
    parameter int unsigned COL              = 384,
    parameter int unsigned AXIS_TDATA_WIDTH = 14
) (
    input  logic                        axis_aclk,
    input  logic                        axis_aresetn,
    input  logic                        s_axis_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tuser,
    input  logic                        s_axis_tlast,
    output logic                        s_axis_tready,
    output logic                        m_axis_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tuser,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready,
    output logic                        frame_done,
    output logic                        err_early_eol,
    output logic                        err_late_eol,
    output logic                        err_early_sof,
    output logic [15:0]                 err_cnt
);
    localparam int unsigned RowW = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int unsigned ColW = (COL > 1) ? $clog2(COL) : 1;
    localparam logic [RowW-1:0] RowLast = RowW'(ROW - 1);
    localparam logic [ColW-1:0] ColLast = ColW'(COL - 1);

    typedef enum logic [2:0] {StWaitSof, StPass, StPadLine, StDropLine, StPadFrame} state_e;

    state_e                        state_q, state_d;
    logic [RowW-1:0]               row_q, row_d;
    logic [ColW-1:0]               col_q, col_d;
    logic [AXIS_TDATA_WIDTH-1:0]   pad_q, pad_d;
    logic                          m_valid_q, m_valid_d;
    logic [AXIS_TDATA_WIDTH-1:0]   m_data_q, m_data_d;
    logic                          m_user_q, m_user_d;
    logic                          m_last_q, m_last_d;
    logic                          final_q, final_d;
    logic [15:0]                   err_cnt_q, err_cnt_d;
    // Low for the first cycle after reset so s_axis_tready reads 0 while in reset.
    logic                          live_q;

    logic load_ok, load, load_pad;
    logic at_last_col, at_last_row, at_end;

    assign load_ok     = !m_valid_q || m_axis_tready;
    assign at_last_col = (col_q == ColLast);
    assign at_last_row = (row_q == RowLast);
    assign at_end      = at_last_col && at_last_row;

    // State and datapath registers.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q   <= StWaitSof;
            row_q     <= '0;
            col_q     <= '0;
            pad_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_user_q  <= 1'b0;
            m_last_q  <= 1'b0;
            final_q   <= 1'b0;
            err_cnt_q <= '0;
            live_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            pad_q     <= pad_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_user_q  <= m_user_d;
            m_last_q  <= m_last_d;
            final_q   <= final_d;
            err_cnt_q <= err_cnt_d;
            live_q    <= 1'b1;
        end
    end

    // Per-state handshake, load strobe and error pulses.
    always_comb begin
        s_axis_tready = 1'b0;
        load          = 1'b0;
        load_pad      = 1'b0;
        err_early_eol = 1'b0;
        err_late_eol  = 1'b0;
        err_early_sof = 1'b0;
        unique case (state_q)
            StWaitSof: begin
                // Non-SOF beats are swallowed; the SOF beat waits for room in the output stage.
                s_axis_tready = live_q && (!s_axis_tuser || load_ok);
                load          = live_q && s_axis_tvalid && s_axis_tuser && load_ok;
            end
            StPass: begin
                s_axis_tready = load_ok && !s_axis_tuser;
                load          = s_axis_tvalid && !s_axis_tuser && load_ok;
                err_early_sof = s_axis_tvalid && s_axis_tuser;
            end
            StPadLine, StPadFrame: begin
                load     = load_ok;
                load_pad = 1'b1;
            end
            StDropLine: begin
                s_axis_tready = !s_axis_tuser;
                err_early_sof = s_axis_tvalid && s_axis_tuser;
            end
            default: ;
        endcase
        if (load && !load_pad) begin
            err_early_eol = s_axis_tlast && !at_last_col;
            err_late_eol  = !s_axis_tlast && at_last_col;
        end
    end

    // Next-state selection; loading the last pixel of a frame always returns to WaitSof.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitSof, StPass: begin
                if (load) begin
                    if (err_early_eol)     state_d = StPadLine;
                    else if (err_late_eol) state_d = StDropLine;
                    else                   state_d = StPass;
                end else if (err_early_sof) begin
                    state_d = StPadFrame;
                end
            end
            StPadLine:  if (load && at_last_col) state_d = StPass;
            StDropLine: begin
                if (err_early_sof)                      state_d = StPadFrame;
                else if (s_axis_tvalid && s_axis_tlast) state_d = StPass;
            end
            StPadFrame: ;
            default:    state_d = StWaitSof;
        endcase
        if (load && at_end) state_d = StWaitSof;
    end

    // Output stage, position counters, pad value and error counter.
    always_comb begin
        row_d     = row_q;
        col_d     = col_q;
        pad_d     = pad_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_user_d  = m_user_q;
        m_last_d  = m_last_q;
        final_d   = final_q;
        err_cnt_d = err_cnt_q;
        if (load) begin
            m_valid_d = 1'b1;
            m_data_d  = load_pad ? pad_q : s_axis_tdata;
            m_user_d  = (row_q == '0) && (col_q == '0);
            m_last_d  = at_last_col;
            final_d   = at_end;
            pad_d     = m_data_d;
            if (at_last_col) begin
                col_d = '0;
                row_d = at_last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end else if (m_axis_tready) begin
            m_valid_d = 1'b0;
        end
        if ((err_early_eol || err_late_eol || err_early_sof) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tuser  = m_user_q;
    assign m_axis_tlast  = m_last_q;
    assign frame_done    = m_valid_q && m_axis_tready && final_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_dpc_axis_frame_sync.sv
// Bench for dpc_axis_frame_sync on a reduced 4x8 frame: a scenario table with hand-computed
// totals, a line-level reference model of the repaired stream, random back-pressure runs and
// a mid-frame reset.
module tb_dpc_axis_frame_sync;
    localparam int ROW = 4;
    localparam int COL = 8;
    localparam int W   = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         s_valid, s_user, s_last, s_ready;
    logic [W-1:0] s_data;
    logic         m_valid, m_user, m_last, m_ready;
    logic [W-1:0] m_data;
    logic         frame_done, e_eol, l_eol, e_sof;
    logic [15:0]  err_cnt;

    dpc_axis_frame_sync #(.ROW(ROW), .COL(COL), .AXIS_TDATA_WIDTH(W)) dut (
        .axis_aclk     (clk),
        .axis_aresetn  (rst_n),
        .s_axis_tvalid (s_valid),
        .s_axis_tdata  (s_data),
        .s_axis_tuser  (s_user),
        .s_axis_tlast  (s_last),
        .s_axis_tready (s_ready),
        .m_axis_tvalid (m_valid),
        .m_axis_tdata  (m_data),
        .m_axis_tuser  (m_user),
        .m_axis_tlast  (m_last),
        .m_axis_tready (m_ready),
        .frame_done    (frame_done),
        .err_early_eol (e_eol),
        .err_late_eol  (l_eol),
        .err_early_sof (e_sof),
        .err_cnt       (err_cnt)
    );

    typedef struct packed {
        logic [W-1:0] data;
        logic         user;
        logic         last;
    } beat_t;

    // kind: 0 clean, 1 short line (len=kval), 2 long line (len=kval), 3 SOF at (krow,kval)
    typedef struct {
        int junk; int kind; int krow; int kval;
        int e_errs; int e_beats; int e_frames;
    } vec_t;

    beat_t stim[$];
    beat_t exp_q[$];
    int    exp_errs, exp_frames;
    int    checks = 0;
    int    errors = 0;
    int    dc = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic void push_pix(input logic [W-1:0] d, input int pos);
        beat_t b;
        b.data = d;
        b.user = (pos == 0);
        b.last = ((pos % COL) == COL - 1);
        exp_q.push_back(b);
    endfunction

    // Line-level model: each frame is ROW lines of COL pixels; short lines are padded with the
    // last pixel, long lines truncated, and a premature SOF pads the rest of the frame.
    function automatic void model();
        int i;
        int pos;
        int n;
        bit cut;
        bit stall;
        logic [W-1:0] pad;
        i = 0;
        pad = '0;
        stall = 0;
        exp_q.delete();
        exp_errs = 0;
        exp_frames = 0;
        while (i < stim.size() && !stall) begin
            if (!stim[i].user) begin
                i++;
                continue;
            end
            pos = 0;
            cut = 0;
            for (int r = 0; r < ROW && !cut && !stall; r++) begin
                n = 0;
                while (n < COL) begin
                    if (i >= stim.size()) begin stall = 1; break; end
                    if (stim[i].user && pos != 0) begin cut = 1; break; end
                    pad = stim[i].data;
                    push_pix(pad, pos);
                    pos++; n++; i++;
                    if (stim[i-1].last) break;
                end
                if (stall || cut) break;
                if (n < COL) begin
                    exp_errs++;
                    while (n < COL) begin push_pix(pad, pos); pos++; n++; end
                end else if (!stim[i-1].last) begin
                    exp_errs++;
                    if (r < ROW - 1) begin
                        while (i < stim.size() && !stim[i].last && !stim[i].user) i++;
                        if (i < stim.size() && stim[i].user) cut = 1;
                        else if (i < stim.size()) i++;
                    end
                end
            end
            if (cut) begin
                exp_errs++;
                while (pos < ROW * COL) begin push_pix(pad, pos); pos++; end
            end
            if (pos == ROW * COL) exp_frames++;
        end
    endfunction

    function automatic void gen_frame(input int junk, input int kind, input int krow,
                                      input int kval);
        int len;
        bit stop;
        stop = 0;
        for (int j = 0; j < junk; j++) stim.push_back({W'(dc++), 1'b0, 1'((j % 5) == 4)});
        for (int r = 0; r < ROW && !stop; r++) begin
            len = ((kind == 1 || kind == 2) && r == krow) ? kval : COL;
            for (int c = 0; c < len; c++) begin
                if (kind == 3 && r == krow && c == kval) begin stop = 1; break; end
                stim.push_back({W'(dc++), 1'(r == 0 && c == 0), 1'(c == len - 1)});
            end
        end
    endfunction

    function automatic void gen_random(input int nframes);
        int len;
        int cut_r;
        int cut_c;
        bit stop;
        for (int f = 0; f < nframes; f++) begin
            cut_r = ROW;
            cut_c = 0;
            stop = 0;
            if (f < nframes - 1 && $urandom_range(99) < 25) begin
                cut_r = $urandom_range(ROW - 1);
                cut_c = $urandom_range(COL - 1);
                if (cut_r == 0 && cut_c == 0) cut_c = 1;
            end
            for (int j = 0; j < int'($urandom_range(3)); j++)
                stim.push_back({W'($urandom), 1'b0, 1'($urandom_range(1))});
            for (int r = 0; r < ROW && !stop; r++) begin
                len = ($urandom_range(99) < 70) ? COL : int'($urandom_range(COL + 3, 2));
                for (int c = 0; c < len; c++) begin
                    if (r == cut_r && c == cut_c) begin stop = 1; break; end
                    stim.push_back({W'($urandom), 1'(r == 0 && c == 0), 1'(c == len - 1)});
                end
            end
        end
    endfunction

    // Drives stim with AXI-legal valid, compares every output beat against the model.
    // abort_at >= 0 asserts reset after that many input handshakes and checks all outputs.
    task automatic run(input int ready_pct, input int gap_pct, input int abort_at,
                       input bit chk_lat, input string tag,
                       output int beats, output int frames, output int errs);
        int si, cyc, sof_cyc, out_cyc;
        bit sent, stalled;
        beat_t held, b;
        logic [15:0] cnt0;
        si = 0; cyc = 0; sof_cyc = -1; out_cyc = -1;
        sent = 0; stalled = 0; held = '0;
        beats = 0; frames = 0; errs = 0;
        cnt0 = err_cnt;
        model();
        while ((si < stim.size() || exp_q.size() > 0 || m_valid) && cyc < 20000) begin
            @(negedge clk);
            if (sent) begin s_valid = 1'b0; sent = 0; si++; end
            if (!s_valid && si < stim.size() && int'($urandom_range(99)) >= gap_pct) begin
                s_valid = 1'b1;
                {s_data, s_user, s_last} = stim[si];
            end
            m_ready = (int'($urandom_range(99)) < ready_pct);
            #1;
            if (stalled) begin
                check({tag, "_hold_valid"}, m_valid, 1);
                check({tag, "_hold_beat"}, {m_data, m_user, m_last}, longint'(held));
            end
            stalled = m_valid && !m_ready;
            held = {m_data, m_user, m_last};
            if (m_valid && out_cyc < 0) out_cyc = cyc;
            if (m_valid && m_ready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    check({tag, "_extra_beat"}, beats, 0);
                end else begin
                    b = exp_q.pop_front();
                    check({tag, "_beat"}, {m_data, m_user, m_last}, longint'(b));
                end
            end
            if (frame_done) frames++;
            errs += int'(e_eol) + int'(l_eol) + int'(e_sof);
            if (s_valid && s_ready) begin
                sent = 1;
                if (s_user && sof_cyc < 0) sof_cyc = cyc;
                if (abort_at >= 0 && si + 1 == abort_at) begin
                    #1 rst_n = 1'b0;
                    #1;
                    check({tag, "_reset_outputs"},
                          {m_valid, m_user, m_last, m_data, s_ready, frame_done,
                           e_eol, l_eol, e_sof, err_cnt}, 0);
                    @(negedge clk);
                    s_valid = 1'b0;
                    repeat (2) @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
            end
            cyc++;
        end
        check({tag, "_timeout"}, cyc < 20000, 1);
        @(negedge clk);
        s_valid = 1'b0;
        check({tag, "_left_expected"}, exp_q.size(), 0);
        check({tag, "_frames_vs_model"}, frames, exp_frames);
        check({tag, "_errs_vs_model"}, errs, exp_errs);
        check({tag, "_err_cnt_delta"}, 16'(err_cnt - cnt0), exp_errs);
        if (chk_lat) check({tag, "_latency"}, out_cyc - sof_cyc, 1);
    endtask

    vec_t tab[8];
    int   nb, nf, ne;

    initial begin
        tab[0] = '{0,  0, 0, 0,  0, 32, 1};  // clean frame
        tab[1] = '{10, 0, 0, 0,  0, 32, 1};  // junk before SOF
        tab[2] = '{0,  1, 1, 4,  1, 32, 1};  // short line mid-frame
        tab[3] = '{0,  2, 2, 10, 1, 32, 1};  // long line mid-frame
        tab[4] = '{0,  3, 2, 3,  1, 64, 2};  // SOF mid-line, then clean frame
        tab[5] = '{0,  1, 3, 5,  1, 32, 1};  // short last line
        tab[6] = '{0,  2, 3, 11, 1, 32, 1};  // long last line, tail dropped idle
        tab[7] = '{0,  3, 1, 0,  1, 64, 2};  // SOF at start of a line

        s_valid = 1'b0; s_user = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_state", {m_valid, m_user, m_last, m_data, s_ready, frame_done,
                              e_eol, l_eol, e_sof, err_cnt}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int t = 0; t < 8; t++) begin
            stim.delete();
            gen_frame(tab[t].junk, tab[t].kind, tab[t].krow, tab[t].kval);
            if (tab[t].kind == 3) gen_frame(0, 0, 0, 0);
            run(100, 0, -1, 1'b1, $sformatf("vec%0d", t), nb, nf, ne);
            check($sformatf("vec%0d_beats", t), nb, tab[t].e_beats);
            check($sformatf("vec%0d_frames", t), nf, tab[t].e_frames);
            check($sformatf("vec%0d_errs", t), ne, tab[t].e_errs);
        end

        // Random streams under 50% back-pressure and idle gaps.
        for (int k = 0; k < 3; k++) begin
            stim.delete();
            gen_random(6);
            run(50, 30, -1, 1'b0, $sformatf("rand%0d", k), nb, nf, ne);
        end

        // Reset in the middle of row 2, then a clean frame must pass untouched.
        stim.delete();
        gen_frame(0, 0, 0, 0);
        run(100, 0, 2 * COL + 3, 1'b0, "abort", nb, nf, ne);
        check("post_reset_err_cnt", err_cnt, 0);
        stim.delete();
        gen_frame(0, 0, 0, 0);
        run(60, 10, -1, 1'b0, "after_reset", nb, nf, ne);
        check("after_reset_beats", nb, ROW * COL);
        check("after_reset_frames", nf, 1);
        check("after_reset_errs", ne, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
